// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings and bit-timing helpers used by TX and RX.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_state_e;

  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  function automatic int unsigned count_reg_len(input int unsigned cpb);
    return 1 + $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: pulses bit_done on the last cycle of every CyclesPerBit-long bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CyclesPerBit = 10,
  parameter int unsigned CountRegLen  = count_reg_len(CyclesPerBit)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam logic [CountRegLen-1:0] LastCount = CountRegLen'(CyclesPerBit - 1);

  logic [CountRegLen-1:0] count_q, count_d;

  assign bit_done = (count_q == LastCount);

  // Restarting at every bit boundary keeps the counter from ever wrapping.
  always_comb begin
    count_d = count_q + CountRegLen'(1);
    if (clear || bit_done) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: holding register + shift register, back-to-back frames, BREAK generation.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_tx_valid,
  output logic                    uart_tx_ready,
  input  logic                    uart_tx_break,
  output logic                    uart_tx_busy,
  output logic                    uart_txd
);

  localparam int unsigned CyclesPerBit = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned CountRegLen  = count_reg_len(CyclesPerBit);

  localparam logic [3:0] LastData  = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0] LastStop  = 4'(STOP_BITS - 1);
  localparam logic [3:0] BreakHigh = 4'(PAYLOAD_BITS + STOP_BITS + 1);
  localparam logic [3:0] LastBreak = 4'(PAYLOAD_BITS + 2 * STOP_BITS);

  uart_state_e             state_q, state_d;
  logic [PAYLOAD_BITS-1:0] hold_q;
  logic                    hold_full_q, hold_full_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic                    txd_q, txd_d;
  logic                    bit_done;
  logic                    take;
  logic                    accept;

  uart_bit_timer #(
    .CyclesPerBit(CyclesPerBit),
    .CountRegLen (CountRegLen)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == StIdle),
    .bit_done(bit_done)
  );

  assign uart_tx_ready = !hold_full_q && !reset;
  assign accept        = uart_tx_valid && uart_tx_ready;
  assign uart_tx_busy  = (state_q != StIdle);
  assign uart_txd      = txd_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    take      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (uart_tx_en && uart_tx_break) begin
          state_d   = StBreak;
          bit_cnt_d = '0;
        end else if (uart_tx_en && hold_full_q) begin
          state_d = StStart;
          take    = 1'b1;
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LastData) begin
            state_d   = StStop;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StStop: begin
        if (bit_done) begin
          if (bit_cnt_q == LastStop) begin
            // Chain straight into the next frame so there is no idle gap.
            if (uart_tx_en && hold_full_q) begin
              state_d = StStart;
              take    = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StBreak: begin
        if (bit_done) begin
          if (bit_cnt_q == LastBreak) state_d = StIdle;
          else                        bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take) shift_d = hold_q;

    hold_full_d = hold_full_q;
    if (take)        hold_full_d = 1'b0;
    else if (accept) hold_full_d = 1'b1;

    // txd is registered, so it is decoded from the next state to line up with it.
    unique case (state_d)
      StIdle:  txd_d = 1'b1;
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      StStop:  txd_d = 1'b1;
      StBreak: txd_d = (bit_cnt_d >= BreakHigh);
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      txd_q       <= txd_d;
      if (accept) hold_q <= uart_tx_data;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard queue filled by stimulus, line decoder pops it.
module tb_uart_tx;

  localparam int unsigned ClkHz   = 1_000_000;
  localparam int unsigned BitRate = 100_000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, valid, ready, brk, busy, txd;
  logic [7:0] data;
  logic       en2, valid2, ready2, busy2, txd2;
  logic       brk2 = 1'b0;
  logic [7:0] data2;

  uart_tx #(
    .BIT_RATE(BitRate), .CLK_HZ(ClkHz), .PAYLOAD_BITS(8), .STOP_BITS(1)
  ) dut (
    .clk(clk), .reset(reset), .uart_tx_en(en), .uart_tx_data(data), .uart_tx_valid(valid),
    .uart_tx_ready(ready), .uart_tx_break(brk), .uart_tx_busy(busy), .uart_txd(txd)
  );

  uart_tx #(
    .BIT_RATE(BitRate), .CLK_HZ(ClkHz), .PAYLOAD_BITS(8), .STOP_BITS(2)
  ) dut2 (
    .clk(clk), .reset(reset), .uart_tx_en(en2), .uart_tx_data(data2), .uart_tx_valid(valid2),
    .uart_tx_ready(ready2), .uart_tx_break(brk2), .uart_tx_busy(busy2), .uart_txd(txd2)
  );

  typedef struct packed {
    logic       brk;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic b, input logic [7:0] d);
    exp_t e;
    e.brk  = b;
    e.data = d;
    return e;
  endfunction

  // Length of the most recent continuous busy period, in cycles.
  int   busy_run = 0;
  int   last_busy_len = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (busy) busy_run = busy_run + 1;
    else begin
      if (busy_prev) last_busy_len = busy_run;
      busy_run = 0;
    end
    busy_prev = busy;
  end

  // Line decoder: samples each bit near its middle and checks against the queue head.
  initial begin : monitor
    logic [9:0] s;
    int         low_len;
    logic       is_brk;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && txd === 1'b0) begin
        repeat (4) @(negedge clk);
        s[0] = txd;
        for (int i = 1; i < 10; i++) begin
          repeat (10) @(negedge clk);
          s[i] = txd;
        end
        is_brk  = (s == 10'd0);
        low_len = 0;
        if (is_brk) begin
          low_len = 95;
          @(negedge clk);
          while (txd === 1'b0 && low_len < 400) begin
            low_len++;
            @(negedge clk);
          end
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame got %0h expected none", s);
        end else begin
          e = exp_q.pop_front();
          check("frame_kind", 32'(is_brk), 32'(e.brk));
          if (e.brk) begin
            check("break_low_len", low_len, 100);
          end else begin
            check("frame_start", 32'(s[0]), 0);
            check("frame_data", 32'(s[8:1]), 32'(e.data));
            check("frame_stop", 32'(s[9]), 1);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    data  = d;
    valid = 1'b1;
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("send_ready_timeout", 0, 1);
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("wait_idle_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0]  table_bytes [6];
    logic [10:0] bits;
    int          n, lows, nbusy;

    table_bytes = '{8'h01, 8'h80, 8'h3C, 8'h96, 8'h5A, 8'hC3};
    reset = 1'b1; en = 1'b1; valid = 1'b0; data = '0; brk = 1'b0;
    en2 = 1'b0; valid2 = 1'b0; data2 = '0;

    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_txd2", 32'(txd2), 1);
    reset = 1'b0;
    #1 check("ready_after_rst", 32'(ready), 1);

    // Single 0xA5: txd falls one cycle after accept, busy for one 100-cycle frame.
    exp_q.push_back(mk(1'b0, 8'hA5));
    @(negedge clk);
    data = 8'hA5; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    check("a5_ready_fell", 32'(ready), 0);
    @(negedge clk) check("a5_txd_before", 32'(txd), 1);
    @(negedge clk) check("a5_txd_fall", 32'(txd), 0);
    wait_idle();
    @(negedge clk) check("a5_busy_len", last_busy_len, 100);

    // Back-to-back 0x00 then 0xFF with valid held.
    exp_q.push_back(mk(1'b0, 8'h00));
    exp_q.push_back(mk(1'b0, 8'hFF));
    @(negedge clk);
    data = 8'h00; valid = 1'b1;
    @(posedge clk);
    #1 data = 8'hFF;
    n = 0;
    @(negedge clk);
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("b2b_ready_wait", n, 1);
    @(posedge clk);
    #1 valid = 1'b0;
    check("b2b_ready_low", 32'(ready), 0);
    wait_idle();
    @(negedge clk) check("b2b_busy_len", last_busy_len, 200);

    // Directed loopback table; frames must chain with no gaps.
    foreach (table_bytes[i]) begin
      exp_q.push_back(mk(1'b0, table_bytes[i]));
      send(table_bytes[i]);
    end
    wait_idle();
    @(negedge clk) check("table_busy_len", last_busy_len, 600);

    // Break while a word is held: break wins, held word follows.
    @(negedge clk) en = 1'b0;
    exp_q.push_back(mk(1'b1, 8'h00));
    exp_q.push_back(mk(1'b0, 8'h5A));
    send(8'h5A);
    @(negedge clk);
    check("held_txd", 32'(txd), 1);
    check("held_busy", 32'(busy), 0);
    en = 1'b1; brk = 1'b1;
    @(negedge clk) brk = 1'b0;
    check("brk_txd_low", 32'(txd), 0);
    check("brk_ready_held", 32'(ready), 0);
    wait_idle();
    @(negedge clk) check("brk_busy_len", last_busy_len, 110);
    repeat (30) @(negedge clk);
    brk = 1'b1;
    @(negedge clk) brk = 1'b0;
    wait_idle();
    @(negedge clk) check("brk_ignored_len", last_busy_len, 100);

    // Reset during DATA bit 3 with a second word held: both are dropped.
    mon_en = 1'b0;
    @(negedge clk);
    data = 8'h81; valid = 1'b1;
    @(posedge clk);
    #1 data = 8'h42;
    n = 0;
    @(negedge clk);
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (42) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_txd", 32'(txd), 1);
    check("mid_rst_busy", 32'(busy), 0);
    @(negedge clk) reset = 1'b0;
    #1 check("mid_rst_ready", 32'(ready), 1);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("mid_rst_no_tx", lows, 0);
    mon_en = 1'b1;
    exp_q.push_back(mk(1'b0, 8'h3C));
    send(8'h3C);
    wait_idle();

    // en=0 with 0x55 offered, STOP_BITS=2 instance.
    @(negedge clk);
    data2 = 8'h55; valid2 = 1'b1;
    @(posedge clk);
    #1 valid2 = 1'b0;
    check("s2_ready_low", 32'(ready2), 0);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (txd2 !== 1'b1 || busy2 !== 1'b0) lows++;
    end
    check("s2_idle_while_disabled", lows, 0);
    en2 = 1'b1;
    @(negedge clk) check("s2_txd_fall", 32'(txd2), 0);
    bits  = '0;
    nbusy = 0;
    for (int k = 0; k < 130; k++) begin
      if (k % 10 == 4 && k < 110) bits[k / 10] = txd2;
      if (busy2) nbusy++;
      @(negedge clk);
    end
    check("s2_bits", 32'(bits), 32'(11'b110_1010_1010));
    check("s2_busy_len", nbusy, 110);

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
